// File: rtl/io_ctrl.sv
// N-channel IO controller: debounced inputs with edge pulses, LED-style outputs.
// Optional toggle latch on debounced rises: define IO_CTRL_TOGGLE_LATCH_EN.
module io_ctrl #(
    parameter int            SW = 4,
    parameter logic [SW-1:0] OE = {SW{1'b0}},
    parameter logic          DS = 1'b0,
    parameter int            DB = 4,
    parameter int            PD = 6,
    parameter int            BP = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [SW-1:0]   io_i,
    output logic [SW-1:0]   io_o,
    output logic [SW-1:0]   io_oe,
    input  logic            dir_wr,
    input  logic [SW-1:0]   dir_data,
    input  logic            mode_wr,
    input  logic [2*SW-1:0] mode_data,
    input  logic [SW-1:0]   push_req,
    output logic [SW-1:0]   in_state,
    output logic [SW-1:0]   in_rise,
    output logic [SW-1:0]   in_fall,
    output logic [SW-1:0]   in_tog
);

    localparam int CW = $clog2(DB + 1);
    localparam int TW = $clog2(PD + 1);
    localparam int PW = (BP > 1) ? $clog2(BP) : 1;

    typedef enum logic [1:0] {
        M_OFF   = 2'd0,
        M_ON    = 2'd1,
        M_BLINK = 2'd2,
        M_PUSH  = 2'd3
    } mode_e;

    logic [SW-1:0]   s1_q, s2_q;
    logic [SW-1:0]   oe_q, oe_d;
    logic [SW-1:0]   state_q, state_d;
    logic [SW-1:0]   rise_q, rise_d;
    logic [SW-1:0]   fall_q, fall_d;
    logic [SW-1:0]   out_q, out_d;
    logic [2*SW-1:0] mode_q, mode_d;
    logic [CW-1:0]   cnt_q [SW];
    logic [CW-1:0]   cnt_d [SW];
    logic [TW-1:0]   tmr_q [SW];
    logic [TW-1:0]   tmr_d [SW];
    logic [PW-1:0]   presc_q, presc_d;
    logic            phase_q, phase_d;
    logic [SW-1:0]   lvl;
    logic [1:0]      m_new;

    always_comb begin
        oe_d    = dir_wr ? dir_data : oe_q;
        mode_d  = mode_wr ? mode_data : mode_q;
        state_d = state_q;
        rise_d  = '0;
        fall_d  = '0;
        lvl     = '0;
        m_new   = '0;
        presc_d = presc_q + 1'b1;
        phase_d = phase_q;
        if (presc_q == PW'(BP - 1)) begin
            presc_d = '0;
            phase_d = ~phase_q;
        end
        for (int c = 0; c < SW; c++) begin
            // Output channels keep the counter parked and the level frozen
            cnt_d[c] = '0;
            if (!oe_q[c] && (s2_q[c] != state_q[c])) begin
                if (cnt_q[c] == CW'(DB - 1)) begin
                    state_d[c] = s2_q[c];
                    rise_d[c]  = s2_q[c];
                    fall_d[c]  = ~s2_q[c];
                end else begin
                    cnt_d[c] = cnt_q[c] + 1'b1;
                end
            end

            m_new = mode_wr ? mode_data[2*c +: 2] : mode_q[2*c +: 2];
            if (push_req[c] && (m_new == M_PUSH)) begin
                tmr_d[c] = TW'(PD);
            end else if (mode_wr) begin
                tmr_d[c] = '0;
            end else if (tmr_q[c] != '0) begin
                tmr_d[c] = tmr_q[c] - 1'b1;
            end else begin
                tmr_d[c] = tmr_q[c];
            end

            case (mode_q[2*c +: 2])
                M_OFF:   lvl[c] = 1'b0;
                M_ON:    lvl[c] = 1'b1;
                M_BLINK: lvl[c] = phase_q;
                M_PUSH:  lvl[c] = (tmr_q[c] != '0);
                default: lvl[c] = 1'b0;
            endcase
        end
        out_d = lvl ^ {SW{DS}};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q    <= {SW{DS}};
            s2_q    <= {SW{DS}};
            oe_q    <= OE;
            state_q <= {SW{DS}};
            rise_q  <= '0;
            fall_q  <= '0;
            out_q   <= {SW{DS}};
            mode_q  <= '0;
            cnt_q   <= '{default: '0};
            tmr_q   <= '{default: '0};
            presc_q <= '0;
            phase_q <= 1'b0;
        end else begin
            s1_q    <= io_i;
            s2_q    <= s1_q;
            oe_q    <= oe_d;
            state_q <= state_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            out_q   <= out_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            tmr_q   <= tmr_d;
            presc_q <= presc_d;
            phase_q <= phase_d;
        end
    end

`ifdef IO_CTRL_TOGGLE_LATCH_EN
    logic [SW-1:0] tog_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            tog_q <= '0;
        end else begin
            tog_q <= tog_q ^ rise_q;
        end
    end

    assign in_tog = tog_q;
`else
    assign in_tog = '0;
`endif

    assign io_o     = out_q;
    assign io_oe    = oe_q;
    assign in_state = state_q;
    assign in_rise  = rise_q;
    assign in_fall  = fall_q;

endmodule

// File: doc/io_ctrl.md
Name: io_ctrl

Overview:
- Synthesisable, N-channel generic IO controller for buttons, switches and LEDs.
- Per-channel direction register; for input channels, 2-FF synchronisation, debouncing and edge pulses.
- For output channels, four drive modes: off, on, blink, timed push pulse. Default polarity is parametrisable.
- Sits between top-level pads (tristate resolved at top from io_oe/io_o) and control logic / OSD.

Parameters:
- SW, 4, channel count.
- OE, {SW{1'b0}}, SW-bit reset direction vector; 1 = output.
- DS, 1'b0, inactive (off) pad level; applies to io_o and to in_state reset.
- DB, 4, debounce stable-cycle count, >=1.
- PD, 6, push pulse length in cycles, >=1.
- BP, 8, blink half-period in cycles, >=1.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- io_i  in  SW  raw pad inputs.
- io_o  out  SW  pad output values.
- io_oe  out  SW  pad output enables; 1 = drive.
- dir_wr  in  1  load strobe for dir_data.
- dir_data  in  SW  new direction vector.
- mode_wr  in  1  load strobe for mode_data.
- mode_data  in  2*SW  per-channel mode; bits [2c+1:2c] belong to channel c. 0 = OFF, 1 = ON, 2 = BLINK, 3 = PUSH.
- push_req  in  SW  per-channel push trigger, sampled every cycle.
- in_state  out  SW  debounced input level.
- in_rise  out  SW  1-cycle pulse on debounced 0->1.
- in_fall  out  SW  1-cycle pulse on debounced 1->0.
- in_tog  out  SW  toggle latch (optional feature).

Behaviour:
- Reset values:
  - io_oe = OE; mode = 0 on all channels; io_o = {SW{DS}}.
  - Sync FFs = {SW{DS}}; in_state = {SW{DS}}.
  - in_rise = in_fall = in_tog = 0.
  - All counters = 0; blink phase = 0.
- Direction:
  - io_oe <= dir_data on the edge where dir_wr = 1.
  - Otherwise io_oe holds its value.
- Input path (only where io_oe[c] = 0):
  - Two-FF synchroniser s1 -> s2.
  - Per-channel counter cnt, $clog2(DB+1) bits:
    - If s2 == in_state: cnt <= 0.
    - Else if cnt == DB-1: in_state <= s2, cnt <= 0, and the matching rise/fall pulse is asserted for exactly 1 cycle, coincident with the new in_state.
    - Else: cnt++.
  - Latency: in_state changes on rising edge DB+2, counting the first edge that samples the new io_i as edge 1.
  - Any bounce shorter than DB cycles after synchronisation produces no change.
- Output-direction channels:
  - cnt held at 0, in_state frozen, in_rise/in_fall forced to 0.
  - Switching the channel back to input resumes the debounce from the frozen in_state.
- Output path:
  - Internal level lvl[c]; registered io_o[c] = lvl[c] ^ DS. Pads are driven only where io_oe[c] = 1; io_o is still computed on all channels.
  - OFF: lvl = 0.
  - ON: lvl = 1.
  - BLINK: lvl = shared phase bit. A free-running prescaler counts 0..BP-1; phase toggles on wrap. All blinking channels are in phase.
  - PUSH: push_req[c] sampled at edge k loads the channel timer with PD. lvl = 1 while timer != 0; the timer decrements each cycle. Result: io_o is active for exactly PD cycles after edge k.
  - push_req while the timer is active retriggers (reloads PD).
  - push_req is ignored on non-PUSH channels.
- Mode changes:
  - mode <= mode_data on a mode_wr edge; io_o reflects the new mode one cycle later.
  - Any mode write clears that channel's push timer.
  - mode_wr and push_req on the same edge: the new mode is applied first; push is accepted only if the new mode is PUSH.
- Reset mid-operation: all state returns to reset values on the same edge, including active pulses, timers and debounce counters.

Optional Feature:
- Macro: IO_CTRL_TOGGLE_LATCH_EN.
- Defined: in_tog[c] inverts on every cycle where in_rise[c] = 1 (button-to-switch latch). Cleared by rst.
- Not defined: in_tog is tied to 0 and no latch flops exist.

Test Plan (SW=4, DS=0, DB=4, PD=6, BP=8, OE=0000):
- Assert rst 2 cycles -> io_o=0000, io_oe=0000, in_state=0000, in_rise=in_fall=0000.
- io_i[0] 0->1 held stable -> in_state[0]=1 and in_rise[0] high for 1 cycle on edge 6. Then io_i[0] pulses 0 for 3 cycles -> no in_fall, in_state[0] stays 1.
- mode_wr with ch1=ON, ch2=BLINK -> io_o[1]=1 from the next cycle; io_o[2] toggles every 8 cycles (16-cycle period).
- ch3=PUSH, push_req[3] one cycle -> io_o[3]=1 for 6 cycles. A second push_req 3 cycles after the first -> io_o[3]=1 for 9 cycles total.
- dir_wr with 0001, then toggle io_i[0] -> io_oe=0001, no in_rise/in_fall on ch0, in_state[0] frozen.
- rst during an active push and a blink -> io_o=0000 on the next edge. With IO_CTRL_TOGGLE_LATCH_EN defined, two debounced rises on ch0 -> in_tog[0] goes 1 then 0.
